// File: rtl/ls_pattern_gen.sv
// Serial stimulus generator for the shift-chain error counter: flush, marker, pattern passes, drain.
// Define LS_PATGEN_PRBS_EN to add a PRBS7 source on MODE 2'b11 (otherwise MODE 2'b11 is checkerboard).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for START, DATA low
// FLUSH | CHAIN_LEN zeros to clear the DUT chain
// MARK  | single one so the counter sees a clean rising edge on Q
// RUN   | pattern passes of CHAIN_LEN bits until a pending STOP at wrap
// DRAIN | CHAIN_LEN zeros to push the last pass out to the counter
module ls_pattern_gen #(
    parameter int CHAIN_LEN = 64,
    parameter int PASS_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic [1:0]        MODE,
    output logic              DATA,
    output logic              SYNC,
    output logic              BUSY,
    output logic              DONE,
    output logic [PASS_W-1:0] PASS_CNT
);

    localparam int CNT_W = ($clog2(CHAIN_LEN) < 1) ? 1 : $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_MARK  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]        state, state_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [CNT_W-1:0]  tmr, tmr_nx;
    logic [1:0]        mode_q, mode_nx;
    logic              stop_pend, stop_pend_nx;
    logic [PASS_W-1:0] pass_q, pass_nx;
    logic              data_q, data_nx;
    logic              sync_q, sync_nx;
    logic              done_q, done_nx;
    logic              pat_bit;
    logic              idx_b1;

    // bit 1 of the index only exists for chains longer than two bits
    if (CNT_W > 1) begin : g_idx_b1
        assign idx_b1 = bit_cnt[1];
    end else begin : g_idx_b1_zero
        assign idx_b1 = 1'b0;
    end

`ifdef LS_PATGEN_PRBS_EN
    logic [6:0] lfsr;
    logic       lfsr_seed;
    logic       lfsr_adv;

    assign lfsr_seed = (state == ST_IDLE) && START;
    assign lfsr_adv  = (state == ST_RUN);

    // x^7 + x^6 + 1, Fibonacci; free-running across passes, reseeded only at START
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr <= 7'h7F;
        end else if (lfsr_seed) begin
            lfsr <= 7'h7F;
        end else if (lfsr_adv) begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end
`endif

    always_comb begin
        pat_bit = ~bit_cnt[0];
        case (mode_q)
            2'b01:   pat_bit = 1'b1;
            2'b10:   pat_bit = ~idx_b1;
`ifdef LS_PATGEN_PRBS_EN
            2'b11:   pat_bit = lfsr[6];
`else
            2'b11:   pat_bit = ~bit_cnt[0];
`endif
            default: pat_bit = ~bit_cnt[0];
        endcase
    end

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        tmr_nx       = tmr;
        mode_nx      = mode_q;
        stop_pend_nx = stop_pend;
        pass_nx      = pass_q;
        done_nx      = 1'b0;
        case (state)
            ST_IDLE: begin
                stop_pend_nx = 1'b0;
                if (START) begin
                    state_nx   = ST_FLUSH;
                    mode_nx    = MODE;
                    pass_nx    = '0;
                    bit_cnt_nx = '0;
                    tmr_nx     = LAST_IDX;
                end
            end
            ST_FLUSH: begin
                if (STOP) stop_pend_nx = 1'b1;
                if (tmr == '0) begin
                    state_nx = ST_MARK;
                end else begin
                    tmr_nx = tmr - CNT_W'(1);
                end
            end
            ST_MARK: begin
                if (STOP) stop_pend_nx = 1'b1;
                state_nx   = ST_RUN;
                bit_cnt_nx = '0;
            end
            ST_RUN: begin
                if (bit_cnt == LAST_IDX) begin
                    if (pass_q != {PASS_W{1'b1}}) pass_nx = pass_q + PASS_W'(1);
                    bit_cnt_nx = '0;
                    // a STOP arriving on the wrap cycle itself still ends this pass
                    if (stop_pend || STOP) begin
                        state_nx     = ST_DRAIN;
                        tmr_nx       = LAST_IDX;
                        stop_pend_nx = 1'b0;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + CNT_W'(1);
                    if (STOP) stop_pend_nx = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tmr == '0) begin
                    state_nx = ST_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    tmr_nx = tmr - CNT_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_nx = 1'b0;
        sync_nx = 1'b0;
        case (state)
            ST_MARK: data_nx = 1'b1;
            ST_RUN: begin
                data_nx = pat_bit;
                sync_nx = (bit_cnt == '0);
            end
            default: data_nx = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            tmr       <= '0;
            mode_q    <= 2'b00;
            stop_pend <= 1'b0;
            pass_q    <= '0;
            data_q    <= 1'b0;
            sync_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            tmr       <= tmr_nx;
            mode_q    <= mode_nx;
            stop_pend <= stop_pend_nx;
            pass_q    <= pass_nx;
            data_q    <= data_nx;
            sync_q    <= sync_nx;
            done_q    <= done_nx;
        end
    end

    assign DATA     = data_q;
    assign SYNC     = sync_q;
    assign DONE     = done_q;
    assign BUSY     = (state != ST_IDLE);
    assign PASS_CNT = pass_q;

endmodule

// File: tb/tb_ls_pattern_gen.sv
// Self-checking bench for ls_pattern_gen (CHAIN_LEN=8): table runs, random runs, reset abort.
// A second instance with PASS_W=2 shares all stimulus to cover PASS_CNT saturation.
module tb_ls_pattern_gen;
    localparam int L = 8;

    logic        CLK = 1'b0;
    logic        RST, START, STOP;
    logic [1:0]  MODE;
    logic        DATA, SYNC, BUSY, DONE;
    logic [15:0] PASS_CNT;
    logic        DATA2, SYNC2, BUSY2, DONE2;
    logic [1:0]  PASS_CNT2;

    int checks   = 0;
    int failures = 0;
    int run_id   = 0;
    int prbs [0:1023];

    typedef struct {
        logic [1:0] mode;
        int         stop_t;
        bit         start_stop;
        int         exp_passes;
        logic [7:0] first_bits;
    } vec_t;

    vec_t vecs [8];

    ls_pattern_gen #(.CHAIN_LEN(L), .PASS_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE),
        .DATA(DATA), .SYNC(SYNC), .BUSY(BUSY), .DONE(DONE), .PASS_CNT(PASS_CNT)
    );

    ls_pattern_gen #(.CHAIN_LEN(L), .PASS_W(2)) u_dut_sat (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .MODE(MODE),
        .DATA(DATA2), .SYNC(SYNC2), .BUSY(BUSY2), .DONE(DONE2), .PASS_CNT(PASS_CNT2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pat(input int mode, input int idx, input int r);
        int m;
        m = mode;
`ifndef LS_PATGEN_PRBS_EN
        if (m == 3) m = 0;
`endif
        case (m)
            0:       return (idx % 2 == 0) ? 1 : 0;
            1:       return 1;
            2:       return ((idx / 2) % 2 == 0) ? 1 : 0;
            default: return prbs[r];
        endcase
    endfunction

    // Timeline relative to the START edge: FLUSH t=0..L-1, MARK t=L, RUN for P passes, DRAIN L cycles.
    // Registered outputs seen at sample t reflect the state of interval t-1.
    task automatic expect_at(input int mode, input int t, input int p,
                             output int ctl, output int pass);
        int run_end, idle_t, u, busy, data, sync, done;
        run_end = L + p * L;
        idle_t  = run_end + L + 1;
        u       = t - 1;
        busy    = (t < idle_t) ? 1 : 0;
        done    = (t == idle_t) ? 1 : 0;
        data    = 0;
        sync    = 0;
        if (u == L) begin
            data = 1;
        end else if (u > L && u <= run_end) begin
            data = pat(mode, (u - L - 1) % L, u - L - 1);
            sync = ((u - L - 1) % L == 0) ? 1 : 0;
        end
        ctl  = busy * 8 + data * 4 + sync * 2 + done;
        pass = (t < 1) ? 0 : ((t - 1) / L - 1);
        if (pass < 0) pass = 0;
        if (pass > p) pass = p;
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_run(input logic [1:0] mode, input int ts, input bit start_stop,
                          input bit noise, output int final_pass, output logic [7:0] first_bits);
        int p, run_end, idle_t, ctl, pass, sat;
        p       = (ts <= L) ? 1 : ((ts - L - 1) / L + 1);
        run_end = L + p * L;
        idle_t  = run_end + L + 1;
        first_bits = 8'h00;
        final_pass = -1;
        run_id++;
        START = 1'b1;
        MODE  = mode;
        STOP  = start_stop;
        tick();
        for (int t = 0; t <= idle_t; t++) begin
            expect_at(int'(mode), t, p, ctl, pass);
            sat = (pass > 3) ? 3 : pass;
            check($sformatf("run%0d_t%0d_ctl", run_id, t), {28'd0, BUSY, DATA, SYNC, DONE}, ctl);
            check($sformatf("run%0d_t%0d_pass", run_id, t), {16'd0, PASS_CNT}, pass);
            check($sformatf("run%0d_t%0d_pass_sat", run_id, t), {30'd0, PASS_CNT2}, sat);
            if (t >= L + 2 && t <= L + 9) first_bits[L + 9 - t] = DATA;
            if (t == idle_t) final_pass = int'(PASS_CNT);
            START = noise && (t < idle_t) && ($urandom_range(0, 3) == 0);
            MODE  = noise ? 2'($urandom_range(0, 3)) : mode;
            STOP  = (t == ts) || (noise && t > run_end && ($urandom_range(0, 2) == 0));
            tick();
        end
        START = 1'b0;
        STOP  = 1'b0;
    endtask

    initial begin
        int         fp, ctl, pass;
        logic [7:0] fb;

        for (int n = 0; n < 1024; n++) prbs[n] = (n < 7) ? 1 : (prbs[n - 7] ^ prbs[n - 6]);

        vecs[0] = '{2'd0, 28, 1'b0, 3, 8'b10101010};
        vecs[1] = '{2'd2, 11, 1'b0, 1, 8'b11001100};
        vecs[2] = '{2'd1, 22, 1'b1, 2, 8'b11111111};
`ifdef LS_PATGEN_PRBS_EN
        vecs[3] = '{2'd3, 17, 1'b0, 2, 8'b11111110};
        vecs[7] = '{2'd3, 15, 1'b0, 1, 8'b11111110};
`else
        vecs[3] = '{2'd3, 17, 1'b0, 2, 8'b10101010};
        vecs[7] = '{2'd3, 15, 1'b0, 1, 8'b10101010};
`endif
        vecs[4] = '{2'd0, 43, 1'b0, 5, 8'b10101010};
        vecs[5] = '{2'd1, 3,  1'b0, 1, 8'b11111111};
        vecs[6] = '{2'd2, 8,  1'b0, 1, 8'b11001100};

        RST   = 1'b1;
        START = 1'b0;
        STOP  = 1'b0;
        MODE  = 2'b00;
        #1;
        check("reset_ctl", {28'd0, BUSY, DATA, SYNC, DONE}, 0);
        check("reset_pass", {16'd0, PASS_CNT}, 0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        check("post_reset_ctl", {28'd0, BUSY, DATA, SYNC, DONE}, 0);

        for (int i = 0; i < 8; i++) begin
            do_run(vecs[i].mode, vecs[i].stop_t, vecs[i].start_stop, 1'b1, fp, fb);
            check($sformatf("tbl%0d_passes", i), fp, vecs[i].exp_passes);
            check($sformatf("tbl%0d_first_bits", i), {24'd0, fb}, int'(vecs[i].first_bits));
        end

        for (int k = 0; k < 6; k++) begin
            do_run(2'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 1'b0, 1'b1, fp, fb);
        end

        // reset mid-run in the second pass: immediate zeros, no DONE, next run replays FLUSH
        START = 1'b1;
        MODE  = 2'b00;
        tick();
        START = 1'b0;
        for (int t = 0; t < 2 * L + 5; t++) begin
            expect_at(0, t, 4, ctl, pass);
            check($sformatf("pre_rst_t%0d_ctl", t), {28'd0, BUSY, DATA, SYNC, DONE}, ctl);
            tick();
        end
        check("pre_rst_pass", {16'd0, PASS_CNT}, 1);
        #2 RST = 1'b1;
        #1;
        check("async_rst_ctl", {28'd0, BUSY, DATA, SYNC, DONE}, 0);
        check("async_rst_pass", {16'd0, PASS_CNT}, 0);
        check("async_rst_pass_sat", {30'd0, PASS_CNT2}, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst_hold%0d_ctl", c), {28'd0, BUSY, DATA, SYNC, DONE}, 0);
        end
        RST = 1'b0;
        tick();
        check("rst_release_ctl", {28'd0, BUSY, DATA, SYNC, DONE}, 0);
        do_run(2'd0, 20, 1'b0, 1'b0, fp, fb);
        check("after_rst_passes", fp, 2);
        check("after_rst_bits", {24'd0, fb}, 8'b10101010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ls_pattern_gen.md
Name: ls_pattern_gen

Overview:
- Stimulus stage directly upstream of the shift-chain error counter.
- Drives the serial DATA bit stream into the 12nm DUT shift/latch chain and, in parallel, to the error counter as the expected-data reference.
- Sequences flush, marker, pattern and drain phases so the counter sees one clean rising edge on Q to arm its comparison.
- Reports busy status, a per-pass sync strobe and a pass count.

Parameters:
- CHAIN_LEN, 64, DUT chain length in bits. Legal range 2..65535.
- PASS_W, 16, width of PASS_CNT.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request to begin a run. Sampled in IDLE only.
- STOP  in  1  single-cycle request to end a run after the current pass.
- MODE  in  2  pattern select, captured at START.
- DATA  out  1  serial stimulus bit to DUT and counter, registered.
- SYNC  out  1  one-cycle strobe on the first bit of every pattern pass.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle strobe on the DRAIN->IDLE transition.
- PASS_CNT  out  PASS_W  completed pattern passes this run, saturating.

Behaviour:
- Reset values: all outputs 0. FSM state = IDLE. Bit counter = 0. Captured mode = 0. LFSR = 7'h7F.
- Reset mid-run aborts immediately and asynchronously to the reset values. There is no drain.
- FSM state IDLE:
  - DATA = 0.
  - START=1 -> FLUSH. Same edge: capture MODE, clear PASS_CNT, reseed LFSR, clear bit counter.
- FSM state FLUSH:
  - DATA = 0 for exactly CHAIN_LEN cycles to clear the chain.
  - Then -> MARK.
- FSM state MARK:
  - DATA = 1 for exactly 1 cycle.
  - Then -> RUN with bit counter = 0.
- FSM state RUN:
  - DATA = pattern bit at index bit counter.
  - Bit counter counts 0..CHAIN_LEN-1 and wraps to 0.
  - SYNC = 1 in the cycle where bit counter = 0.
  - On wrap, PASS_CNT increments; it saturates at all-ones.
- FSM state DRAIN:
  - DATA = 0 for CHAIN_LEN cycles to flush the last pass out to the counter.
  - Then -> IDLE with DONE = 1 for that cycle.
- STOP handling:
  - Held pending in a sticky flag from the edge it is seen in FLUSH, MARK or RUN.
  - Acted on only at the RUN wrap (bit counter = CHAIN_LEN-1): -> DRAIN instead of wrapping.
  - The PASS_CNT increment for that final pass still occurs.
  - STOP in IDLE or DRAIN is ignored.
  - START and STOP together in IDLE: START wins and STOP is ignored.
- START while BUSY is ignored.
- MODE changes after capture are ignored until the next START.
- DATA, SYNC and DONE are registered, so the state decision for cycle n appears on the outputs at edge n+1. Latency START -> first FLUSH zero is 1 clock.
- Bit counter width: clog2(CHAIN_LEN), minimum 1. Compare against CHAIN_LEN-1, with no reliance on natural overflow.
- Pattern per captured MODE (i = bit counter):
  - 00: checkerboard, DATA = ~i[0], giving 1,0,1,0...
  - 01: all ones.
  - 10: double checkerboard, DATA = ~i[1], giving 1,1,0,0...
  - 11: PRBS7 (see Optional Feature).
- Patterns restart from index 0 every pass. The LFSR does not restart per pass.

Optional Feature:
- Macro LS_PATGEN_PRBS_EN.
- Defined:
  - MODE 11 selects PRBS7, polynomial x^7+x^6+1, Fibonacci form, seed 7'h7F loaded at START.
  - DATA = LFSR[6]. The LFSR advances once per RUN cycle only and holds in all other states.
  - First 8 RUN bits after seed: 1,1,1,1,1,1,1,0.
- Undefined:
  - No LFSR is instantiated.
  - MODE 11 behaves exactly as MODE 00 (checkerboard).

Test Plan (bench CHAIN_LEN=8):
1. Reset, MODE=00, START pulse:
   - BUSY rises 1 clk later.
   - DATA = 8x0, then 1, then 1,0,1,0,1,0,1,0 repeating.
   - SYNC on each pass start.
   - PASS_CNT = 1, 2, 3 at 8-cycle intervals.
2. MODE=10 run, STOP pulsed at RUN bit index 2 of pass 1:
   - Pass completes (1,1,0,0,1,1,0,0).
   - PASS_CNT = 1.
   - 8 zeros in DRAIN, DONE pulse, BUSY low.
3. START and STOP asserted together in IDLE:
   - Run starts normally and STOP has no effect.
   - START re-pulsed during RUN is ignored: PASS_CNT is not cleared.
4. RST asserted mid-RUN at pass 2:
   - All outputs go to 0 immediately with no DONE pulse.
   - Subsequent START replays the FLUSH sequence from the beginning.
5. MODE=11 with LS_PATGEN_PRBS_EN defined:
   - First RUN bits 1,1,1,1,1,1,1,0.
   - Sequence continues across the pass boundary without reseed.
   - Without the macro, the same stimulus gives 1,0,1,0...
6. PASS_W=2, run of 5 passes:
   - PASS_CNT = 1, 2, 3, 3, 3 (saturates).
   - DONE asserted after STOP as normal.
